// File: rtl/pmem_arbiter.sv
// Two-client line arbiter (I-cache, D-cache) onto a single physical-memory port.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is D-over-I priority.
module pmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t state, state_next;
    logic   last_grant, last_grant_next;   // 0 = I, 1 = D
    logic   i_req, d_req;

    assign i_req   = i_read | i_write;
    assign d_req   = d_read | d_write;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;

        case (state)
            IDLE: begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                if (i_req && d_req) begin
                    state_next = last_grant ? SERVE_I : SERVE_D;
                end else if (d_req) begin
                    state_next = SERVE_D;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end
`else
                if (d_req) begin
                    state_next = SERVE_D;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end
`endif
            end

            SERVE_I: begin
                mem_read    = i_read;
                mem_write   = i_write;
                mem_address = i_address;
                mem_wdata   = i_wdata;
                i_resp      = mem_resp;
                if (mem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b0;
                end
            end

            SERVE_D: begin
                mem_read    = d_read;
                mem_write   = d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                d_resp      = mem_resp;
                if (mem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed literal cases plus randomized clients and
// memory checked every cycle against a transaction-level ownership model.
module tb_pmem_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_address, d_address;
    logic [LINE_W-1:0] i_wdata, d_wdata;
    logic              i_resp, d_resp;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              mem_read, mem_write, mem_resp;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_address  (i_address),
        .i_wdata    (i_wdata),
        .i_resp     (i_resp),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_resp     (d_resp),
        .d_rdata    (d_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: who owns the downstream port this cycle (-1 none, 0 I, 1 D) and who finished last.
    int owner = -1;
    int last  = 1;
    int n_done_i = 0;
    int n_done_d = 0;
    bit sb_en = 1'b0;
    logic [LINE_W-1:0] mem_arr [8];

    function automatic int line_idx(logic [ADDR_W-1:0] a);
        return int'(a[7:5]);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one cycle.
    always @(negedge clk) begin : compare
        logic              e_mr, e_mw, e_ir, e_dr, ir, dr;
        logic [ADDR_W-1:0] e_ma;
        logic [LINE_W-1:0] e_wd;
        if (!rst_n) begin
            owner = -1;
            last  = 1;
            for (int k = 0; k < 8; k++) mem_arr[k] = {8{32'hC0DE_0000 + 32'(k)}};
        end
        e_mr = 1'b0; e_mw = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_ma = '0; e_wd = '0;
        if (owner == 0) begin
            e_mr = i_read; e_mw = i_write; e_ma = i_address; e_wd = i_wdata; e_ir = mem_resp;
        end else if (owner == 1) begin
            e_mr = d_read; e_mw = d_write; e_ma = d_address; e_wd = d_wdata; e_dr = mem_resp;
        end
        chk("mem_read",    LINE_W'(mem_read),    LINE_W'(e_mr));
        chk("mem_write",   LINE_W'(mem_write),   LINE_W'(e_mw));
        chk("mem_address", LINE_W'(mem_address), LINE_W'(e_ma));
        chk("mem_wdata",   mem_wdata,            e_wd);
        chk("i_resp",      LINE_W'(i_resp),      LINE_W'(e_ir));
        chk("d_resp",      LINE_W'(d_resp),      LINE_W'(e_dr));
        chk("i_rdata",     i_rdata,              mem_rdata);
        chk("d_rdata",     d_rdata,              mem_rdata);

        if (rst_n && owner >= 0 && mem_resp) begin
            if (sb_en && owner == 0) begin
                if (i_read) chk("i_line", i_rdata, mem_arr[line_idx(i_address)]);
                if (i_write) mem_arr[line_idx(i_address)] = i_wdata;
            end else if (sb_en && owner == 1) begin
                if (d_read) chk("d_line", d_rdata, mem_arr[line_idx(d_address)]);
                if (d_write) mem_arr[line_idx(d_address)] = d_wdata;
            end
            if (owner == 0) n_done_i++;
            else            n_done_d++;
            last  = owner;
            owner = -1;
        end else if (rst_n && owner < 0) begin
            ir = i_read | i_write;
            dr = d_read | d_write;
            if (ir && dr) owner = RR ? ((last == 1) ? 0 : 1) : 1;
            else if (dr)  owner = 1;
            else if (ir)  owner = 0;
        end
    end

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    // Two simultaneous reads with 3-cycle memory; `first` is the client expected to win.
    task automatic pair_test(input int first);
        int srv;
        i_read = 1'b1; i_address = 32'h100;
        d_read = 1'b1; d_address = 32'h200;
        mem_resp = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            wait_cyc();
            if (c == 4) begin
                if (first == 0) i_read = 1'b0; else d_read = 1'b0;
            end
            if (c == 8) begin
                i_read = 1'b0; d_read = 1'b0;
            end
            mem_resp  = (c == 3 || c == 7);
            mem_rdata = rand_line();
            #1;
            srv = (c >= 1 && c <= 3) ? first : (c >= 5 && c <= 7) ? 1 - first : -1;
            chk("pair_mem_read", LINE_W'(mem_read), LINE_W'(srv >= 0));
            if (srv >= 0) chk("pair_addr", LINE_W'(mem_address), (srv == 1) ? LINE_W'(32'h200) : LINE_W'(32'h100));
            chk("pair_i_resp", LINE_W'(i_resp), LINE_W'(srv == 0 && (c == 3 || c == 7)));
            chk("pair_d_resp", LINE_W'(d_resp), LINE_W'(srv == 1 && (c == 3 || c == 7)));
        end
        mem_resp = 1'b0;
    endtask

    initial begin : stim
        int lat, cnt, seen_i, seen_d;
        logic [LINE_W-1:0] pat;
        rst_n = 1'b0;
        i_read = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_resp = 1'b1; mem_rdata = {32{8'h5A}};

        // Reset: outputs idle even with mem_resp high, rdata passes through.
        repeat (3) wait_cyc();
        chk("rst_mem_read",  LINE_W'(mem_read),    '0);
        chk("rst_mem_write", LINE_W'(mem_write),   '0);
        chk("rst_mem_addr",  LINE_W'(mem_address), '0);
        chk("rst_mem_wdata", mem_wdata,            '0);
        chk("rst_i_resp",    LINE_W'(i_resp),      '0);
        chk("rst_d_resp",    LINE_W'(d_resp),      '0);
        chk("rst_i_rdata",   i_rdata,              {32{8'h5A}});
        mem_resp = 1'b0;
        rst_n = 1'b1;
        wait_cyc();

        // I read only.
        i_read = 1'b1; i_address = 32'h0000_1000;
        wait_cyc();
        chk("ird_mem_read", LINE_W'(mem_read),    LINE_W'(1'b1));
        chk("ird_mem_addr", LINE_W'(mem_address), LINE_W'(32'h1000));
        repeat (4) wait_cyc();
        pat = {32{8'hA5}};
        mem_resp = 1'b1; mem_rdata = pat;
        #1;
        chk("ird_i_resp", LINE_W'(i_resp), LINE_W'(1'b1));
        chk("ird_i_rdata", i_rdata, pat);
        chk("ird_d_resp", LINE_W'(d_resp), '0);
        wait_cyc();
        i_read = 1'b0; mem_resp = 1'b0;
        #1;
        chk("ird_after", LINE_W'(mem_read), '0);

        // D write with 4-cycle memory.
        wait_cyc();
        pat = {16{16'h1234}};
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = pat;
        for (int c = 1; c <= 4; c++) begin
            wait_cyc();
            mem_resp = (c == 4);
            #1;
            chk("dwr_mem_write", LINE_W'(mem_write), LINE_W'(1'b1));
            chk("dwr_mem_wdata", mem_wdata, pat);
            chk("dwr_mem_addr",  LINE_W'(mem_address), LINE_W'(32'h8000_0040));
            chk("dwr_d_resp",    LINE_W'(d_resp), LINE_W'(c == 4));
        end
        wait_cyc();
        d_write = 1'b0; mem_resp = 1'b0;
        #1;
        chk("dwr_after", LINE_W'(mem_write), '0);

        // Simultaneous pairs, back to back.
        wait_cyc();
        pair_test(RR ? 0 : 1);
        pair_test(RR ? 0 : 1);
        pair_test(RR ? 0 : 1);

        // Reset during a D write.
        wait_cyc();
        d_write = 1'b1; d_address = 32'h40; d_wdata = rand_line();
        wait_cyc();
        #1;
        chk("rmid_pre_write", LINE_W'(mem_write), LINE_W'(1'b1));
        rst_n = 1'b0; mem_resp = 1'b1;
        #1;
        chk("rmid_mem_write", LINE_W'(mem_write), '0);
        chk("rmid_d_resp",    LINE_W'(d_resp),    '0);
        d_write = 1'b0; mem_resp = 1'b0;
        wait_cyc();
        rst_n = 1'b1;
        i_read = 1'b1; i_address = 32'h2000;
        wait_cyc();
        chk("rmid_grant",  LINE_W'(mem_read),    LINE_W'(1'b1));
        chk("rmid_addr",   LINE_W'(mem_address), LINE_W'(32'h2000));
        mem_resp = 1'b1;
        #1;
        chk("rmid_i_resp", LINE_W'(i_resp), LINE_W'(1'b1));

        // Zero-wait memory: continuous I read responds every second cycle.
        wait_cyc();
        i_address = 32'h60;
        for (int k = 0; k < 8; k++) begin
            chk("zw_mem_read", LINE_W'(mem_read), LINE_W'(k % 2 == 1));
            chk("zw_i_resp",   LINE_W'(i_resp),   LINE_W'(k % 2 == 1));
            wait_cyc();
        end
        i_read = 1'b0; mem_resp = 1'b0;
        repeat (2) wait_cyc();

        // Randomized clients and memory with 0..3 wait states.
        sb_en = 1'b1;
        cnt = 0; lat = 0;
        seen_i = n_done_i; seen_d = n_done_d;
        for (int c = 0; c < 3000; c++) begin
            if (n_done_i != seen_i) begin
                seen_i = n_done_i; i_read = 1'b0; i_write = 1'b0;
            end
            if (n_done_d != seen_d) begin
                seen_d = n_done_d; d_read = 1'b0; d_write = 1'b0;
            end
            if (!(i_read | i_write) && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 1) == 1) i_read = 1'b1; else i_write = 1'b1;
                i_address = 32'($urandom_range(0, 7)) << 5;
                i_wdata   = rand_line();
            end
            if (!(d_read | d_write) && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 1) == 1) d_read = 1'b1; else d_write = 1'b1;
                d_address = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5);
                d_wdata   = rand_line();
            end
            mem_resp = 1'b0;
            mem_rdata = rand_line();
            if (owner >= 0) begin
                if (cnt == 0) lat = $urandom_range(0, 3);
                if (cnt == lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_arr[line_idx((owner == 1) ? d_address : i_address)];
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            wait_cyc();
        end
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        chk("rand_i_progress", LINE_W'(n_done_i - seen_i > 0 || seen_i > 100), LINE_W'(1'b1));
        chk("rand_d_progress", LINE_W'(n_done_d > 100), LINE_W'(1'b1));
        repeat (2) wait_cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
